// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle between an upstream producer, the
// ALU command sequencer and the downstream result consumer.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [SEL_W-1:0] cmd_sel;
  logic             cmd_acc;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_acc, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_acc, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO, issues them one at a time and holds each
// result until drained. Optional accumulator operand via ALU_SEQ_ACC_EN.
module alu_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_cmd_sequencer_if.slave   bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [SEL_W-1:0]     alu_s,
  input  logic [WIDTH-1:0]     alu_y,
  output logic                 busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic             acc;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop, capture, release_res;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] res_q;
  logic             res_vld_q;

  assign full          = (count == FULL_CNT);
  assign empty         = (count == '0);
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign head          = mem[rd_ptr];
  assign busy          = (state_q != IDLE) || !empty;
  assign bus.res_valid = res_vld_q;
  assign bus.res_data  = res_q;

`ifdef ALU_SEQ_ACC_EN
  logic [WIDTH-1:0] acc_q;
  always_ff @(posedge clk) begin
    if (rst)          acc_q <= '0;
    else if (capture) acc_q <= alu_y;
  end
  assign next_a = head.acc ? acc_q : head.a;
`else
  logic unused_acc;
  assign unused_acc = head.acc;
  assign next_a     = head.a;
`endif

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: if (res_vld_q && bus.res_ready) begin
        release_res = 1'b1;
        // Chain straight into the next command to keep a 2-cycle cadence.
        if (!empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage has no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= '{acc: bus.cmd_acc, sel: bus.cmd_sel,
                                       b: bus.cmd_b, a: bus.cmd_a};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        alu_a  <= next_a;
        alu_b  <= head.b;
        alu_s  <= head.sel;
      end
      if (capture) begin
        res_q     <= alu_y;
        res_vld_q <= 1'b1;
      end else if (release_res) begin
        res_vld_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer driving an adder ALU stub (y = a + b).
module tb_alu_cmd_sequencer;
  localparam int WIDTH = 4;
  localparam int SEL_W = 3;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [SEL_W-1:0] alu_s;
  logic             busy;

  alu_cmd_sequencer_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus();

  alu_cmd_sequencer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .alu_a (alu_a),
    .alu_b (alu_b),
    .alu_s (alu_s),
    .alu_y (alu_y),
    .busy  (busy)
  );

  assign alu_y = alu_a + alu_b;

  always #5 clk = ~clk;

  typedef struct { int a; int b; int s; int y; } exp_t;
  exp_t sb[$];

  int n_checks  = 0;
  int n_fail    = 0;
  int model_acc = 0;
  int cyc       = 0;
  int last_hs   = 0;
  bit have_last = 0;
  bit tput_on   = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: results leave on a handshake, commands enter on acceptance.
  always @(negedge clk) begin : mon
    exp_t e;
    int   a_eff;
    if (!tput_on) have_last = 0;
    if (rst) begin
      sb.delete();
      model_acc = 0;
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", int'(bus.res_data), -1);
        end else begin
          e = sb.pop_front();
          chk("res_data", int'(bus.res_data), e.y);
          chk("alu_a", int'(alu_a), e.a);
          chk("alu_b", int'(alu_b), e.b);
          chk("alu_s", int'(alu_s), e.s);
        end
        if (tput_on) begin
          if (have_last) chk("tput_gap", cyc - last_hs, 2);
          last_hs   = cyc;
          have_last = 1;
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        a_eff = int'(bus.cmd_a);
`ifdef ALU_SEQ_ACC_EN
        if (bus.cmd_acc) a_eff = model_acc;
`endif
        e.a = a_eff;
        e.b = int'(bus.cmd_b);
        e.s = int'(bus.cmd_sel);
        e.y = (a_eff + int'(bus.cmd_b)) % 16;
        model_acc = e.y;
        sb.push_back(e);
      end
    end
  end

  task automatic push(input int a, input int b, input int s, input int acc);
    bit got = 0;
    bus.cmd_a     = 4'(a);
    bus.cmd_b     = 4'(b);
    bus.cmd_sel   = 3'(s);
    bus.cmd_acc   = 1'(acc);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        got = 1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("push_accept", int'(got), 1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("idle_reached", int'(ok), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    bit got;
    int stale;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sel   = '0;
    bus.cmd_acc   = 1'b0;
    bus.res_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_alu_a", int'(alu_a), 0);
    chk("rst_alu_b", int'(alu_b), 0);
    chk("rst_alu_s", int'(alu_s), 0);
    chk("rst_res_data", int'(bus.res_data), 0);

    // Single command latency
    bus.cmd_a = 4'd2; bus.cmd_b = 4'd9; bus.cmd_sel = 3'd0; bus.cmd_acc = 1'b0;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("lat_e0_busy", int'(busy), 1);
    chk("lat_e0_res_valid", int'(bus.res_valid), 0);
    @(posedge clk); #1;
    chk("lat_e1_alu_a", int'(alu_a), 2);
    chk("lat_e1_alu_b", int'(alu_b), 9);
    chk("lat_e1_res_valid", int'(bus.res_valid), 0);
    @(posedge clk); #1;
    chk("lat_e2_res_valid", int'(bus.res_valid), 1);
    chk("lat_e2_res_data", int'(bus.res_data), 11);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    chk("lat_idle_busy", int'(busy), 0);
    chk("lat_idle_res_valid", int'(bus.res_valid), 0);

    // Wrap-around of the 4-bit sum
    push(9, 9, 1, 0);
    wait_idle(20);
    chk("wrap_res_data", int'(bus.res_data), 2);

    // Fill and stall: one issued plus DEPTH queued, then the sixth is held off
    bus.res_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(k + 1, 3 * k, k, 0);
    chk("fill_cmd_ready", int'(bus.cmd_ready), 0);
    chk("fill_res_valid", int'(bus.res_valid), 1);
    bus.cmd_a = 4'd7; bus.cmd_b = 4'd7; bus.cmd_sel = 3'd5; bus.cmd_acc = 1'b0;
    bus.cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("fill_blocked", int'(bus.cmd_ready), 0);
    end
    @(posedge clk); #1;
    tput_on = 1'b1;
    bus.res_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        got = 1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("fill_sixth_accepted", int'(got), 1);
    wait_idle(60);
    tput_on = 1'b0;

    // Accumulate
    push(3, 4, 0, 0);
    push(6, 5, 0, 1);
    wait_idle(30);
`ifdef ALU_SEQ_ACC_EN
    chk("acc_second", int'(bus.res_data), 12);
`else
    chk("acc_second", int'(bus.res_data), 11);
`endif

    // Opcode pass-through
    for (int s = 0; s < 8; s++) push(s, 15 - s, s, 0);
    wait_idle(80);

    // Reset in DONE with two commands still queued
    bus.res_ready = 1'b0;
    push(5, 6, 3, 0);
    push(7, 1, 6, 0);
    push(2, 2, 7, 0);
    chk("rmid_res_valid", int'(bus.res_valid), 1);
    rst = 1'b1;
    bus.cmd_a = 4'd1; bus.cmd_b = 4'd1; bus.cmd_sel = 3'd1; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("rmid_res_valid_clr", int'(bus.res_valid), 0);
    chk("rmid_busy", int'(busy), 0);
    chk("rmid_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rmid_alu_a", int'(alu_a), 0);
    chk("rmid_alu_b", int'(alu_b), 0);
    chk("rmid_alu_s", int'(alu_s), 0);
    chk("rmid_res_data", int'(bus.res_data), 0);
    bus.res_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.res_valid || busy) stale++;
    end
    chk("rmid_no_stale", stale, 0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      bus.cmd_valid = 1'($urandom);
      bus.cmd_a     = 4'($urandom);
      bus.cmd_b     = 4'($urandom);
      bus.cmd_sel   = 3'($urandom);
      bus.cmd_acc   = 1'($urandom);
      bus.res_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    wait_idle(200);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream command stage for the 4-bit `alu` datapath.
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU's `a`, `b` and `s` inputs from registers that stay stable for one execute cycle.
- Captures the ALU's combinational `y` into a result register that a downstream consumer drains with its own valid/ready handshake.

## Interface
- `WIDTH`, 4: operand/result width; matches ALU `a`, `b`, `y`.
- `SEL_W`, 3: opcode width; matches ALU `s`.
- `DEPTH`, 4: command FIFO depth; must be a power of two, ≥2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: FIFO can accept; equals `!full`.
- `cmd_a` input WIDTH: operand A.
- `cmd_b` input WIDTH: operand B.
- `cmd_sel` input SEL_W: ALU opcode.
- `cmd_acc` input 1: use the previous result as operand A. Honoured only with `ALU_SEQ_ACC_EN`.
- `alu_a` output WIDTH: registered, to ALU `a`.
- `alu_b` output WIDTH: registered, to ALU `b`.
- `alu_s` output SEL_W: registered, to ALU `s`.
- `alu_y` input WIDTH: from ALU `y`; combinational function of `alu_a`, `alu_b`, `alu_s`.
- `res_valid` output 1: result available.
- `res_ready` input 1: consumer takes the result.
- `res_data` output WIDTH: captured ALU result.
- `busy` output 1: high whenever state ≠ IDLE or the FIFO is non-empty.

## Operation
- **FIFO:** stores `{cmd_acc, cmd_sel, cmd_b, cmd_a}`. Push occurs when `cmd_valid && cmd_ready`. Pointers are log2(DEPTH) bits and wrap naturally; the count is log2(DEPTH)+1 bits.
- **FSM states:** IDLE, EXEC, DONE.
  - **IDLE:** if the FIFO is non-empty, pop the head, load `alu_a/alu_b/alu_s`, and go to EXEC. Otherwise stay.
  - **EXEC:** operands are held. At the clock edge, `res_data <= alu_y` and `res_valid <= 1`, then go to DONE.
  - **DONE:** hold `res_valid`, `res_data` and the ALU operands. When `res_valid && res_ready`:
    - if the FIFO is non-empty, pop and load the next command in the same edge, clear `res_valid`, and go to EXEC;
    - otherwise clear `res_valid` and go to IDLE.
- Pops happen only in IDLE and in DONE on a result handshake, and never when the FIFO is empty.
- **Simultaneous push and pop:** allowed in the same cycle when not full; the count is unchanged.
- **Push when full:** `cmd_ready` is 0, so nothing is written. `cmd_ready` does not look ahead at a same-cycle pop.
- **Arithmetic:** the sequencer does no arithmetic. `res_data` is exactly the ALU's WIDTH-bit output, with no extension or carry.
- **Operands in IDLE:** `alu_a/alu_b/alu_s` keep the last issued command's values.

## Timing
- **Reset** (any cycle, including mid-EXEC/DONE) takes effect at the next edge with `rst=1`:
  - state IDLE, FIFO empty, pointers 0;
  - `alu_a=0`, `alu_b=0`, `alu_s=0`, `res_data=0`, `res_valid=0`;
  - `cmd_ready=1` (combinational, once the FIFO is empty), `busy=0`;
  - the accumulator register clears to 0.
  
  A command presented during reset is dropped.
- **Single-command latency:** command accepted at edge E. The command is issued to the ALU at E+1. `res_valid` rises after E+2.
- **Back-to-back throughput:** with `res_ready` held at 1, one result every 2 cycles (EXEC, DONE alternate).
- **Result hold:** `res_valid` stays high and `res_data` stays stable until the handshake. Stalls are unbounded.
- **FIFO backpressure:** `cmd_ready` deasserts the cycle after the DEPTH-th unpopped push.

## Configuration
- Macro: `ALU_SEQ_ACC_EN`.
- **Defined:** the block has a WIDTH-bit accumulator register.
  - It is loaded with `alu_y` at every EXEC edge and reset to 0.
  - When a popped command has `cmd_acc=1`, `alu_a` is loaded from the accumulator instead of `cmd_a`.
- **Undefined:** no accumulator register. `cmd_acc` is stored but ignored, and `alu_a` always comes from `cmd_a`.

## Test plan
The bench uses an ALU stub with `y = a + b` (mod 16).
- **Single command:** after reset, push a=2, b=9, sel=000 at edge 0 → `alu_a=2`, `alu_b=9` after edge 1; `res_valid=1`, `res_data=4'hB` after edge 2; `res_ready=1` → IDLE, `busy=0`.
- **Wrap:** push a=9, b=9 → `res_data=4'h2`.
- **Fill and stall:** hold `res_ready=0` and push 6 commands → 1 issued, `cmd_ready=0` after 5 accepted (DEPTH=4 plus 1 in flight). Then release `res_ready=1` → results come out in push order, one every 2 cycles, with no loss or duplication.
- **Accumulate (`ALU_SEQ_ACC_EN`):** push (a=3, b=4, acc=0) then (a=x, b=5, acc=1) → results 7 then 12. Without the macro, the second result is x+5.
- **Reset mid-operation:** assert `rst` in DONE with 2 commands queued → next cycle `res_valid=0`, `busy=0`, `cmd_ready=1`, all ALU outputs 0; no stale result appears afterwards.
- **Sel pass-through:** push sel=000…111 sequentially → `alu_s` shows each value during its EXEC cycle.
